uart_text_writer: RTL and testbench
===================================

// Module: uart_text_writer
// PURPOSE
//  Sits between the uart receiver and the character DualPortRAM write port.
//  Converts each received byte into a text-RAM write or a cursor operation.
//  Owns the cursor (row/col), interprets control bytes (CR, LF, BS, FF), and
//  runs a full-screen clear sweep.
//  The VGA text path reads the RAM; this block drives only the write side.
// PARAMETERS
//  COLS   32  characters per row; must equal 2**COL_W
//  ROWS   4   text rows; must equal 2**ROW_W
//  COL_W  5   column index width
//  ROW_W  2   row index width
// PORTS
//  clk       in   1      system clock (100 MHz)
//  reset     in   1      synchronous, active-high reset
//  rx_data   in   8      received byte; valid while rx_valid is high
//  rx_valid  in   1      uart received-byte flag; level, may stay high for many cycles
//  wr_en     out  1      RAM write enable; one-cycle pulse per write
//  wr_row    out  ROW_W  RAM write row address
//  wr_col    out  COL_W  RAM write column address
//  wr_data   out  8      RAM write data
//  cur_row   out  ROW_W  current cursor row
//  cur_col   out  COL_W  current cursor column
//  busy      out  1      high while clear sweep runs; rx bytes are dropped
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: wr_en=0, wr_row=0, wr_col=0, wr_data=0, cur_row=0,
//    cur_col=0, busy=0.
//  - Rising-edge detect on rx_valid. Exactly one event per low->high
//    transition; a held-high level produces no further events.
//  - rx_data is sampled in the same cycle the edge is detected.
//  - FSM states: IDLE, CLEAR. Reset enters IDLE.
//  - IDLE handling of a detected byte b. Every result below is visible on
//    the outputs one cycle after the edge-detect cycle.
//    - b in 0x20..0x7E (printable):
//      - wr_en=1, addr = cursor, wr_data = b.
//      - Cursor advances by one. Col COLS-1 wraps to col 0 of the next row.
//      - Row ROWS-1 wraps to row 0 (no scrolling).
//    - 0x0D (CR): col -> 0, no write.
//    - 0x0A (LF): row -> row+1 mod ROWS, col unchanged, no write.
//    - 0x08 (BS): cursor steps back by one.
//      - Col 0 steps to COLS-1 of the previous row.
//      - At (0,0) the cursor stays at (0,0).
//      - Then writes 0x20 at the new cursor position.
//    - 0x0C (FF): enter CLEAR; busy=1 in the next cycle.
//    - Any other byte, including >=0x80: ignored, no write, cursor unchanged.
//  - CLEAR sweep:
//    - Writes 0x20 to every cell in row-major order, (0,0) first, one cell
//      per cycle.
//    - Takes ROWS*COLS consecutive wr_en cycles (128 by default).
//    - After the last cell (ROWS-1, COLS-1): cursor = (0,0), busy=0,
//      return to IDLE.
//    - rx edges detected during CLEAR are discarded, not queued.
//  - wr_en is never high for two consecutive cycles in IDLE.
//  - In IDLE, wr_row/wr_col/wr_data hold their last values when wr_en=0.
//  - Reset during CLEAR aborts the sweep immediately; all outputs take
//    reset values.
//  - Reset and an rx edge in the same cycle: reset wins, byte dropped.
//  - Index arithmetic is unsigned, modulo 2**COL_W and 2**ROW_W.
// CONFIGURATION
//  CLEAR_ON_RESET_EN
//   - Defined: reset release enters CLEAR instead of IDLE.
//     - busy=1 in the first cycle after reset deasserts.
//     - Full 0x20 sweep, then IDLE, so power-up garbage in RAM is blanked.
//   - Undefined: reset release enters IDLE; RAM contents are untouched.
// TESTING
//  1. Reset, then send 'H'(0x48), 'i'(0x69) -> writes (0,0)=0x48 and
//     (0,1)=0x69, one wr_en pulse each, cursor=(0,2).
//  2. Hold rx_valid high for 50 cycles with 0x41 -> exactly one write;
//     cursor advances by 1.
//  3. Cursor (0,31), send 0x5A -> write at (0,31), cursor=(1,0).
//     Then from cursor (3,31), send 0x5A -> cursor=(0,0).
//  4. Cursor (1,0), send 0x08 -> write 0x20 at (0,31), cursor=(0,31).
//     At (0,0), send 0x08 -> write 0x20 at (0,0), cursor stays (0,0).
//  5. Cursor (2,7), send 0x0D then 0x0A -> no writes, cursor=(3,0).
//     Send 0x07 -> ignored.
//  6. Send 0x0C -> busy high for 128 cycles, 128 writes of 0x20 ending at
//     (3,31), cursor=(0,0). A byte sent mid-sweep is dropped.
//     Repeat with reset mid-sweep -> sweep stops, outputs at reset values.

Source files
------------

// File: rtl/uart_text_writer.sv
// UART byte -> text-RAM writer: owns the cursor, decodes CR/LF/BS/FF, runs the clear sweep.
// Optional: define CLEAR_ON_RESET_EN to blank the whole screen after every reset release.
module uart_text_writer #(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = 5,
  parameter int ROW_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy
);
  localparam int AW = ROW_W + COL_W;
  localparam logic [AW-1:0] LAST = AW'(ROWS * COLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

`ifdef CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t          state, state_n;
  logic            prev_valid;
  logic            rx_edge;
  logic            wr_en_n, busy_n;
  logic [ROW_W-1:0] wr_row_n, cur_row_n;
  logic [COL_W-1:0] wr_col_n, cur_col_n;
  logic [7:0]      wr_data_n;
  logic [AW-1:0]   cur_lin, wr_lin, cur_inc, cur_dec, wr_inc;

  assign rx_edge = rx_valid & ~prev_valid;
  // Row/col concatenated into one linear index so col wrap carries into the row.
  assign cur_lin = {cur_row, cur_col};
  assign wr_lin  = {wr_row, wr_col};
  assign cur_inc = cur_lin + AW'(1);
  assign cur_dec = (cur_lin == '0) ? '0 : cur_lin - AW'(1);
  assign wr_inc  = wr_lin + AW'(1);

  always_comb begin
    state_n   = state;
    wr_en_n   = 1'b0;
    wr_row_n  = wr_row;
    wr_col_n  = wr_col;
    wr_data_n = wr_data;
    cur_row_n = cur_row;
    cur_col_n = cur_col;
    busy_n    = busy;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (rx_edge) begin
          if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
            wr_en_n                = 1'b1;
            wr_row_n               = cur_row;
            wr_col_n               = cur_col;
            wr_data_n              = rx_data;
            {cur_row_n, cur_col_n} = cur_inc;
          end else begin
            case (rx_data)
              8'h0D: cur_col_n = '0;
              8'h0A: cur_row_n = cur_row + ROW_W'(1);
              8'h08: begin
                wr_en_n                = 1'b1;
                {wr_row_n, wr_col_n}   = cur_dec;
                {cur_row_n, cur_col_n} = cur_dec;
                wr_data_n              = 8'h20;
              end
              8'h0C: begin
                state_n   = CLEAR;
                busy_n    = 1'b1;
                wr_en_n   = 1'b1;
                wr_row_n  = '0;
                wr_col_n  = '0;
                wr_data_n = 8'h20;
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        wr_data_n = 8'h20;
        if (!busy) begin
          // Entered straight from reset: issue the first cell here.
          busy_n   = 1'b1;
          wr_en_n  = 1'b1;
          wr_row_n = '0;
          wr_col_n = '0;
        end else if (wr_lin == LAST) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          cur_row_n = '0;
          cur_col_n = '0;
        end else begin
          wr_en_n              = 1'b1;
          {wr_row_n, wr_col_n} = wr_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Track rx_valid through reset so a level held across reset is not an edge.
    prev_valid <= rx_valid;
    if (reset) begin
      state   <= RST_STATE;
      wr_en   <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
      cur_row <= '0;
      cur_col <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      wr_en   <= wr_en_n;
      wr_row  <= wr_row_n;
      wr_col  <= wr_col_n;
      wr_data <= wr_data_n;
      cur_row <= cur_row_n;
      cur_col <= cur_col_n;
      busy    <= busy_n;
    end
  end
endmodule

// File: tb/tb_uart_text_writer.sv
// Scoreboard bench for uart_text_writer: expected RAM writes queued on send, popped on wr_en.
module tb_uart_text_writer;
  logic       clk = 0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_en, busy;
  logic [1:0] wr_row, cur_row;
  logic [4:0] wr_col, cur_col;
  logic [7:0] wr_data;

  uart_text_writer dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int wr_cnt = 0, busy_cnt = 0;
  logic [14:0] exp_q[$];
  int mr = 0, mc = 0;  // model cursor

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", {17'd0, wr_row, wr_col, wr_data}, 32'hFFFF_FFFF);
      else chk("write", {17'd0, wr_row, wr_col, wr_data}, {17'd0, exp_q.pop_front()});
    end
  end

  task automatic raw_send(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b; rx_valid = 1;
    repeat (hold) @(negedge clk);
    rx_valid = 0;
    @(negedge clk);
  endtask

  // Update the model, queue the expected writes, then drive the byte.
  task automatic send(input logic [7:0] b, input int hold = 1);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({mr[1:0], mc[4:0], b});
      if (mc == 31) begin mc = 0; mr = (mr == 3) ? 0 : mr + 1; end
      else mc = mc + 1;
    end else if (b == 8'h0D) mc = 0;
    else if (b == 8'h0A) mr = (mr + 1) % 4;
    else if (b == 8'h08) begin
      if (mc != 0) mc = mc - 1;
      else if (mr != 0) begin mr = mr - 1; mc = 31; end
      exp_q.push_back({mr[1:0], mc[4:0], 8'h20});
    end else if (b == 8'h0C) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 32; c++) begin
          logic [1:0] rr; logic [4:0] cc;
          rr = r[1:0]; cc = c[4:0];
          exp_q.push_back({rr, cc, 8'h20});
        end
      mr = 0; mc = 0;
    end
    raw_send(b, hold);
  endtask

  task automatic chk_cur(input string tag, input int r, input int c);
    chk(tag, {25'd0, cur_row, cur_col}, (r << 5) | c);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    int w0;
    reset = 1; rx_valid = 0; rx_data = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_outs", {wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy}, 0);

    // 1: "Hi"
    w0 = wr_cnt;
    send(8'h48); send(8'h69);
    chk("hi_writes", wr_cnt - w0, 2);
    chk_cur("hi_cursor", 0, 2);

    // 2: held level -> one event
    w0 = wr_cnt;
    send(8'h41, 50);
    chk("hold_writes", wr_cnt - w0, 1);
    chk_cur("hold_cursor", 0, 3);

    // 3: column wrap and full-screen wrap
    for (int i = 0; i < 28; i++) send(8'h61 + 8'(i % 26));
    chk_cur("pre_colwrap", 0, 31);
    send(8'h5A);
    chk_cur("colwrap", 1, 0);

    // 4: backspace across row boundary and at origin
    send(8'h08);
    chk_cur("bs_wrap", 0, 31);
    chk("bs_wdata", wr_data, 8'h20);
    send(8'h0D);
    w0 = wr_cnt;
    send(8'h08);
    chk("bs_origin_writes", wr_cnt - w0, 1);
    chk_cur("bs_origin", 0, 0);

    repeat (3) send(8'h0A);
    for (int i = 0; i < 31; i++) send(8'h30 + 8'(i % 10));
    chk_cur("pre_scrwrap", 3, 31);
    send(8'h5A);
    chk_cur("scrwrap", 0, 0);

    // 5: CR/LF/ignored bytes
    send(8'h0A); send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h2E);
    chk_cur("at_2_7", 2, 7);
    w0 = wr_cnt;
    send(8'h0D); send(8'h0A);
    chk_cur("crlf", 3, 0);
    send(8'h07); send(8'h85); send(8'h7F);
    chk("ctrl_no_writes", wr_cnt - w0, 0);
    chk_cur("ignored", 3, 0);
    chk("hold_wdata", wr_data, 8'h2E);

    // 6: clear sweep with a dropped mid-sweep byte
    busy_cnt = 0; w0 = wr_cnt;
    send(8'h0C);
    chk("ff_busy", busy, 1);
    raw_send(8'h58, 1);
    wait_idle("sweep");
    @(negedge clk);
    chk("sweep_busy_cycles", busy_cnt, 128);
    chk("sweep_writes", wr_cnt - w0, 128);
    chk("sweep_last_addr", {wr_row, wr_col}, {2'd3, 5'd31});
    chk_cur("sweep_cursor", 0, 0);
    chk("sweep_q_empty", exp_q.size(), 0);
    send(8'h42);
    chk_cur("post_sweep", 0, 1);

    // reset mid-sweep aborts
    send(8'h0C);
    repeat (20) @(negedge clk);
    reset = 1;
    @(negedge clk);
    exp_q.delete(); mr = 0; mc = 0;
    chk("abort_outs", {wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy}, 0);
    reset = 0;
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    chk("abort_quiet", wr_cnt - w0, 0);
    chk("abort_busy", busy, 0);

    // reset coincident with an rx edge: byte dropped
    rx_data = 8'h41; rx_valid = 1; reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    rx_valid = 0;
    @(negedge clk);
    chk("rst_edge_writes", wr_cnt - w0, 0);
    chk_cur("rst_edge_cursor", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
